uart_rx_deser: RTL and testbench

UART receive deserializer for the RV32I MCU's UART peripheral. It samples the serial `UART_RX_DSER` line, recovers 8N1 frames, and presents each received byte on a single-entry valid/ready output toward the peripheral's register/AXI front end. In the loopback bench it is the stage that consumes what the UART transmitter drives onto `UART_TX_DSER`.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx_deser.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_deser.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and baud divisor helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

    localparam int UART_DATA_BITS = 8;

    // System clocks per serial bit, truncated; shared with the transmitter.
    function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs; resets to all ones.
// Latency: two clk_i cycles from input change to q_o.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver feeding a single-entry valid/ready output register.
// Byte or error pulse appears one cycle after the stop sample; a full, undrained register drops the new byte.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 500_000_000,
    parameter int unsigned BAUD_RATE       = 115200
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      UART_RX_DSER,
    output logic [UART_DATA_BITS-1:0] RX_DATA,
    output logic                      RX_VALID,
    input  logic                      RX_READY,
    output logic                      RX_FERR,
    output logic                      RX_OVERRUN
);

    localparam int unsigned      CPB      = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int               CNT_W    = $clog2(CPB);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);

    logic                      rx_s;

    uart_rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                bidx_q, bidx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      frame_done;
    logic                      stop_hi;

    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      ferr_q, ferr_d;
    logic                      ovr_q, ovr_d;
    logic                      can_load;

    sync_2ff #(
        .WIDTH (1)
    ) u_rx_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (UART_RX_DSER),
        .q_o   (rx_s)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bidx_d     = bidx_q;
        shift_d    = shift_q;
        frame_done = 1'b0;
        stop_hi    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            // Mid-bit check of the start bit filters short low glitches.
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                        bidx_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d           = '0;
                    shift_d[bidx_q] = rx_s;
                    bidx_d          = bidx_q + 3'd1;
                    if (bidx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    state_d    = IDLE;
                    frame_done = 1'b1;
                    stop_hi    = rx_s;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A byte may land in the same cycle the consumer drains the old one.
    assign can_load = !valid_q || RX_READY;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (valid_q && RX_READY) begin
            valid_d = 1'b0;
        end

        if (frame_done) begin
            if (!stop_hi) begin
                ferr_d = 1'b1;
            end else if (can_load) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign RX_DATA    = data_q;
    assign RX_VALID   = valid_q;
    assign RX_FERR    = ferr_q;
    assign RX_OVERRUN = ovr_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser at 10 clocks per bit.
module tb_uart_rx_deser;
    import uart_pkg::*;

    localparam int unsigned CF  = 500_000_000;
    localparam int unsigned BR  = 50_000_000;
    localparam int          CPB = 10;
    // Line fall to registered result: 2 sync + half bit + 9 bits + 1 output register.
    localparam int          LAT = 2 + CPB / 2 + 9 * CPB + 1;

    localparam logic [2:0] EV_VALID = 3'b100;
    localparam logic [2:0] EV_FERR  = 3'b010;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       line = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_FERR;
    logic       RX_OVERRUN;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int last_fall = 0;
    bit mon_en = 1'b0;

    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int hs_cnt = 0;
    int ovr_at = 0;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         at;
    } evt_t;

    typedef struct {
        logic [7:0] b;
        logic       stop_ok;
        int         gap;
        logic [2:0] kind;
        logic [7:0] data;
    } vec_t;

    evt_t expq[$];

    uart_rx_deser #(
        .CLOCK_FREQUENCY (CF),
        .BAUD_RATE       (BR)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .UART_RX_DSER (line),
        .RX_DATA      (RX_DATA),
        .RX_VALID     (RX_VALID),
        .RX_READY     (ready),
        .RX_FERR      (RX_FERR),
        .RX_OVERRUN   (RX_OVERRUN)
    );

    initial forever #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            if (RX_FERR) ferr_cnt <= ferr_cnt + 1;
            if (RX_OVERRUN) begin
                ovr_cnt <= ovr_cnt + 1;
                ovr_at  <= cyc;
            end
            if (RX_VALID && ready) hs_cnt <= hs_cnt + 1;
        end
    end

    // Every output event is matched in order against the expected queue.
    always @(negedge CLK) begin : monitor
        evt_t e;
        if (mon_en && !RST && (RX_VALID || RX_FERR || RX_OVERRUN)) begin
            if (expq.size() == 0) begin
                chk("spurious_evt", 32'({RX_VALID, RX_FERR, RX_OVERRUN}), 32'(0));
            end else begin
                e = expq.pop_front();
                chk("evt_cycle", 32'(cyc), 32'(e.at));
                chk("evt_kind", 32'({RX_VALID, RX_FERR, RX_OVERRUN}), 32'(e.kind));
                chk("evt_data", 32'(RX_DATA), 32'(e.data));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        last_fall = cyc;
        line = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            step(CPB);
        end
        line = stop_ok;
        step(CPB);
        line = 1'b1;
    endtask

    task automatic frame_exp(input logic [7:0] b, input logic stop_ok,
                             input logic [2:0] kind, input logic [7:0] data);
        evt_t e;
        e.kind = kind;
        e.data = data;
        e.at   = cyc + LAT;
        expq.push_back(e);
        send_frame(b, stop_ok);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 400) begin
            step(1);
            n++;
        end
        step(2);
        chk(name, 32'(expq.size()), 32'(0));
        expq.delete();
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[8];
        logic [7:0] last;
        logic [7:0] b;
        logic       ok;
        logic [2:0] kind;
        logic [7:0] data;
        int         ovr0, ferr0, hs0, f2;

        vecs[0] = '{8'h55, 1'b1, 0,  EV_VALID, 8'h55};
        vecs[1] = '{8'hA5, 1'b1, 0,  EV_VALID, 8'hA5};
        vecs[2] = '{8'h3C, 1'b1, 5,  EV_VALID, 8'h3C};
        vecs[3] = '{8'h00, 1'b1, 0,  EV_VALID, 8'h00};
        vecs[4] = '{8'hFF, 1'b0, 20, EV_FERR,  8'h00};
        vecs[5] = '{8'h12, 1'b1, 3,  EV_VALID, 8'h12};
        vecs[6] = '{8'h80, 1'b1, 0,  EV_VALID, 8'h80};
        vecs[7] = '{8'h01, 1'b1, 2,  EV_VALID, 8'h01};

        step(3);
        chk("rst_data", 32'(RX_DATA), 32'(0));
        chk("rst_valid", 32'(RX_VALID), 32'(0));
        chk("rst_ferr", 32'(RX_FERR), 32'(0));
        chk("rst_ovr", 32'(RX_OVERRUN), 32'(0));
        RST = 1'b0;
        step(5);

        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            frame_exp(vecs[i].b, vecs[i].stop_ok, vecs[i].kind, vecs[i].data);
            step(vecs[i].gap);
        end
        drain("table_drain");
        last = 8'h01;

        // Three-cycle low pulse must be rejected at the start-bit midpoint.
        line = 1'b0;
        step(3);
        line = 1'b1;
        step(10);
        chk("glitch_idle", 32'(dut.state_q), 32'(IDLE));
        chk("glitch_valid", 32'(RX_VALID), 32'(0));

        mon_en = 1'b0;
        ready = 1'b0;
        ovr0 = ovr_cnt;
        ferr0 = ferr_cnt;
        send_frame(8'h11, 1'b1);
        chk("ovr_first_valid", 32'(RX_VALID), 32'(1));
        chk("ovr_first_data", 32'(RX_DATA), 32'(8'h11));
        send_frame(8'h22, 1'b1);
        f2 = last_fall;
        step(2);
        chk("ovr_pulses", 32'(ovr_cnt - ovr0), 32'(1));
        chk("ovr_cycle", 32'(ovr_at), 32'(f2 + LAT));
        chk("ovr_data_held", 32'(RX_DATA), 32'(8'h11));
        chk("ovr_valid_held", 32'(RX_VALID), 32'(1));
        chk("ovr_no_ferr", 32'(ferr_cnt - ferr0), 32'(0));
        hs0 = hs_cnt;
        ready = 1'b1;
        step(1);
        chk("ovr_drain_valid", 32'(RX_VALID), 32'(0));
        step(3);
        chk("ovr_one_xfer", 32'(hs_cnt - hs0), 32'(1));
        chk("ovr_drain_data", 32'(RX_DATA), 32'(8'h11));
        mon_en = 1'b1;

        // Abort 0xC3 partway through data bit 4.
        b = 8'hC3;
        line = 1'b0;
        step(CPB);
        for (int i = 0; i < 4; i++) begin
            line = b[i];
            step(CPB);
        end
        line = b[4];
        step(5);
        RST = 1'b1;
        line = 1'b1;
        #1;
        chk("midrst_data", 32'(RX_DATA), 32'(0));
        chk("midrst_valid", 32'(RX_VALID), 32'(0));
        chk("midrst_ferr", 32'(RX_FERR), 32'(0));
        chk("midrst_ovr", 32'(RX_OVERRUN), 32'(0));
        chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
        step(3);
        RST = 1'b0;
        step(20);
        frame_exp(8'h7E, 1'b1, EV_VALID, 8'h7E);
        drain("midrst_drain");
        last = 8'h7E;

        // Random frames: a good stop delivers the byte, a low stop flags an error and leaves RX_DATA alone.
        for (int n = 0; n < 40; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(7, 0) != 0);
            if (ok) begin
                kind = EV_VALID;
                data = b;
                last = b;
            end else begin
                kind = EV_FERR;
                data = last;
            end
            frame_exp(b, ok, kind, data);
            step(ok ? int'($urandom_range(12, 0)) : int'($urandom_range(20, 12)));
        end
        drain("random_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
